program_loader: RTL
===================

# program_loader

Parametrised boot-and-run controller placed between the simulation/debug host and `mips_processor`. It streams a program into instruction memory over a valid/ready interface and holds the core in reset while loading. It then releases the core and counts cycles, detecting halt (PC stuck) or budget timeout. On completion it freezes the core and reports status. It replaces hand-poked memory writes and fixed-delay runs with a reusable, synthesizable sequencer.

## Interface
- `DATA_W`, 32, instruction/PC width
- `ADDR_W`, 10, instruction-memory word-address width (depth = 2^ADDR_W)
- `CYCLE_W`, 16, cycle-counter and budget width
- `HALT_REPEAT`, 4, consecutive cycles of unchanged PC that declare a halt (>=1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `s_valid` in 1: program word valid
- `s_ready` out 1: loader accepts word
- `s_data` in DATA_W: program word
- `s_last` in 1: marks final program word
- `imem_we` out 1: instruction-memory write enable
- `imem_addr` out ADDR_W: word address
- `imem_wdata` out DATA_W: write data
- `core_reset` out 1: active-high reset to processor
- `core_stall` out 1: freeze request to processor (PC/regfile hold)
- `pc` in DATA_W: processor PC (byte address)
- `run_budget` in CYCLE_W: max run cycles; 0 = unlimited
- `restart` in 1: single-cycle pulse, DONE -> LOAD
- `done` out 1: run finished
- `halted` out 1: finished by PC halt
- `timeout` out 1: finished by budget
- `overflow` out 1: program exceeded depth
- `cycles` out CYCLE_W: run cycles elapsed
- `words_loaded` out ADDR_W+1: words written

## Operation
- States: LOAD, RUN, DONE. Reset: state=LOAD, write pointer=0, `cycles`=0, `words_loaded`=0, all flags 0, `core_reset`=1, `core_stall`=0.
- LOAD: `s_ready`=1, `core_reset`=1. Beat accepted when `s_valid & s_ready`. Then `imem_we`=1, `imem_addr`=pointer, `imem_wdata`=`s_data` (combinational pass-through), and pointer and `words_loaded` increment.
  - Accepted beat with `s_last` -> RUN; `run_budget` is latched.
  - Accepted beat at address 2^ADDR_W-1 without `s_last`: the word is written, `overflow`=1, `done`=1, next state DONE. The core is never released.
  - Both conditions on the same beat: `s_last` wins, no overflow.
- RUN: `s_ready`=0, `imem_we`=0, `core_reset`=0, `core_stall`=0. `cycles` increments every RUN cycle and saturates at all-ones.
  - PC tracking: previous-PC register updates every RUN cycle. A repeat counter increments when `pc` equals previous PC and clears otherwise. It is cleared on RUN entry, so the first RUN cycle never counts as a repeat.
  - Repeat counter reaching HALT_REPEAT -> `halted`=1, `done`=1, DONE.
  - Latched budget nonzero and `cycles`+1 == budget -> `timeout`=1, `done`=1, DONE.
  - Halt and timeout in the same cycle: `halted`=1 only.
- DONE: `core_stall`=1, `core_reset`=0 so register state is preserved for inspection. `s_ready`=0. Status outputs hold.
  - `restart` -> LOAD: pointer, `cycles`, `words_loaded` and flags are cleared, and `core_reset`=1 on the next cycle.
  - `restart` in LOAD or RUN is ignored.
- `reset_n` low in any state returns immediately to reset values. A partially loaded program is abandoned; memory contents are not cleared.

## Timing
- Zero-latency write: word accepted at edge N is written at edge N.
- RUN entry: `core_reset` falls on the cycle after the last beat is accepted.
- Halt detection fires HALT_REPEAT+1 RUN cycles after PC first stops changing at the earliest. `done` is registered and rises on the edge that enters DONE.
- Timeout: with budget B, exactly B RUN cycles elapse and `cycles`=B in DONE.
- `done`/`halted`/`timeout`/`overflow` are registered and glitch-free.
- `s_valid` may drop at any time in LOAD; idle cycles are not counted.

## Test plan
- Load 16 words (value = 0x1000_0000+i, `s_last` on i=15) with random `s_valid` gaps -> `imem_addr` 0..15 written once each, `words_loaded`=16, `core_reset` falls the cycle after the last beat.
- Program ending in `j` to self, budget 0, HALT_REPEAT=4 -> `halted`=1, `timeout`=0, `core_stall`=1, `cycles` stable in DONE.
- Non-halting loop, budget 50 -> `timeout`=1, `cycles`=50, `halted`=0.
- ADDR_W=3: 8 words without `s_last` -> all 8 written, `overflow`=1, `done`=1, `core_reset` stays 1. A 9th `s_valid` gets `s_ready`=0.
- PC stuck exactly on the budget cycle (budget 10) -> `halted`=1, `timeout`=0.
- `reset_n` low after 5 words, then reload 3 words; separately pulse `restart` in DONE -> both return to LOAD with counters 0 and `core_reset`=1. The reload writes addresses 0..2.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot-and-run sequencer for mips_processor.
// Streams a program into instruction memory while the core is held in reset, then runs the
// core until its PC stops changing (halt) or a cycle budget expires, and freezes it for
// inspection.
module program_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CYCLE_W     = 16,
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               core_reset,
  output logic               core_stall,
  input  logic [DATA_W-1:0]  pc,
  input  logic [CYCLE_W-1:0] run_budget,
  input  logic               restart,
  output logic               done,
  output logic               halted,
  output logic               timeout,
  output logic               overflow,
  output logic [CYCLE_W-1:0] cycles,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned RepW   = $clog2(HALT_REPEAT + 1);
  localparam int unsigned WordsW = ADDR_W + 1;
  localparam int unsigned CntW   = CYCLE_W + 1;

  typedef enum logic [1:0] {StLoad, StRun, StDone} state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    ptr_q;
  logic [WordsW-1:0]    words_q;
  logic [CYCLE_W-1:0]   cycles_q;
  logic [CYCLE_W-1:0]   budget_q;
  logic [DATA_W-1:0]    prev_pc_q;
  logic [RepW-1:0]      rep_q;
  logic                 first_q;
  logic                 done_q, halted_q, timeout_q, overflow_q;
  logic                 core_reset_q, core_stall_q;

  logic                 accept;
  logic [CYCLE_W-1:0]   cycles_inc;
  logic [RepW-1:0]      rep_next;
  logic                 halt_hit;
  logic                 budget_hit;

  // Load handshake and zero-latency memory write path.
  assign s_ready    = (state_q == StLoad);
  assign accept     = s_valid & s_ready;
  assign imem_we    = accept;
  assign imem_addr  = ptr_q;
  assign imem_wdata = s_data;

  assign core_reset   = core_reset_q;
  assign core_stall   = core_stall_q;
  assign done         = done_q;
  assign halted       = halted_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign cycles       = cycles_q;
  assign words_loaded = words_q;

  // Run-phase next values: saturating cycle count, PC-repeat tracking, end conditions.
  always_comb begin
    cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CYCLE_W'(1);
    // The first RUN cycle compares against a stale PC, so it never counts as a repeat.
    if (first_q || (pc != prev_pc_q)) begin
      rep_next = '0;
    end else begin
      rep_next = rep_q + RepW'(1);
    end
    halt_hit   = (rep_next == RepW'(HALT_REPEAT));
    budget_hit = (budget_q != '0) &&
                 ((CntW'(cycles_q) + CntW'(1)) == CntW'(budget_q));
  end

  // Sequencer FSM with registered status and core-control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StLoad;
      ptr_q        <= '0;
      words_q      <= '0;
      cycles_q     <= '0;
      budget_q     <= '0;
      prev_pc_q    <= '0;
      rep_q        <= '0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
      core_reset_q <= 1'b1;
      core_stall_q <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (accept) begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            words_q <= words_q + WordsW'(1);
            if (s_last) begin
              state_q      <= StRun;
              budget_q     <= run_budget;
              cycles_q     <= '0;
              rep_q        <= '0;
              first_q      <= 1'b1;
              core_reset_q <= 1'b0;
            end else if (ptr_q == '1) begin
              // Program does not fit: stop here and never release the core.
              state_q      <= StDone;
              overflow_q   <= 1'b1;
              done_q       <= 1'b1;
              core_stall_q <= 1'b1;
            end
          end
        end
        StRun: begin
          cycles_q  <= cycles_inc;
          prev_pc_q <= pc;
          rep_q     <= rep_next;
          first_q   <= 1'b0;
          // Halt takes priority over a simultaneous budget expiry.
          if (halt_hit) begin
            state_q      <= StDone;
            halted_q     <= 1'b1;
            done_q       <= 1'b1;
            core_stall_q <= 1'b1;
          end else if (budget_hit) begin
            state_q      <= StDone;
            timeout_q    <= 1'b1;
            done_q       <= 1'b1;
            core_stall_q <= 1'b1;
          end
        end
        StDone: begin
          if (restart) begin
            state_q      <= StLoad;
            ptr_q        <= '0;
            words_q      <= '0;
            cycles_q     <= '0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b1;
            core_stall_q <= 1'b0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
